// File: rtl/dice_pkg.sv
// Shared types and constants for the craps game controller.
package dice_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_D1, S_GAP, S_D2, S_EVAL, S_POINT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OUT_NONE, OUT_WIN, OUT_LOSE, OUT_POINT
  } outcome_t;

  localparam int SUM_W   = 4;
  localparam int DIE_MAX = 6;

  function automatic logic die_ok(input logic [2:0] v);
    return (v != 3'd0) && (v <= 3'(DIE_MAX));
  endfunction

endpackage

// File: rtl/craps_rules.sv
// Combinational craps rule decoder: classifies a throw sum against the current point.
module craps_rules
  import dice_pkg::*;
(
  input  logic [SUM_W-1:0] sum_i,
  input  logic [SUM_W-1:0] point_i,
  output outcome_t         outcome_o
);

  always_comb begin
    outcome_o = OUT_NONE;
    if (point_i == '0) begin
      unique case (sum_i)
        4'd7, 4'd11:        outcome_o = OUT_WIN;
        4'd2, 4'd3, 4'd12:  outcome_o = OUT_LOSE;
        default:            outcome_o = OUT_POINT;
      endcase
    end else if (sum_i == point_i) begin
      outcome_o = OUT_WIN;
    end else if (sum_i == 4'd7) begin
      outcome_o = OUT_LOSE;
    end
  end

endmodule

// File: rtl/craps_ctrl.sv
// Two-dice craps sequencer: drives the roll unit enable, captures both dice,
// and registers the come-out / point-phase result from craps_rules.
module craps_ctrl
  import dice_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       roll_num,
  input  logic             roll_choose,
  output logic             roll_en,
  output logic [2:0]       die1,
  output logic [2:0]       die2,
  output logic [SUM_W-1:0] sum,
  output logic [SUM_W-1:0] point,
  output logic             point_valid,
  output logic             win,
  output logic             lose,
  output logic             busy,
  output logic [CNT_W-1:0] throws
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic             start_q, d2_armed_q, roll_en_q;
  logic [2:0]       die1_q, die1_d, die2_q, die2_d;
  logic [SUM_W-1:0] sum_q, sum_d, point_q, point_d;
  logic             win_q, win_d, lose_q, lose_d;
  logic [CNT_W-1:0] throws_q, throws_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             start_rise;
  outcome_t         outcome;

  assign start_rise = start & ~start_q;

  craps_rules u_rules (
    .sum_i    (sum_q),
    .point_i  (point_q),
    .outcome_o(outcome)
  );

  always_comb begin
    state_d  = state_q;
    die1_d   = die1_q;
    die2_d   = die2_q;
    sum_d    = sum_q;
    point_d  = point_q;
    win_d    = win_q;
    lose_d   = lose_q;
    throws_d = throws_q;
    gap_d    = gap_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_rise) begin
        state_d  = S_D1;
        die1_d   = '0;
        die2_d   = '0;
        sum_d    = '0;
        point_d  = '0;
        win_d    = 1'b0;
        lose_d   = 1'b0;
        throws_d = '0;
      end
      S_POINT: if (start_rise) begin
        state_d = S_D1;
        die1_d  = '0;
        die2_d  = '0;
        sum_d   = '0;
      end
      S_D1: if (roll_choose && die_ok(roll_num)) begin
        die1_d  = roll_num;
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_D2;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      // The unit clears num on the enable edge, so the first D2 cycle is blind.
      S_D2: if (d2_armed_q && roll_choose && die_ok(roll_num)) begin
        die2_d  = roll_num;
        sum_d   = {1'b0, die1_q} + {1'b0, roll_num};
        state_d = S_EVAL;
      end
      S_EVAL: begin
        throws_d = (throws_q == '1) ? throws_q : throws_q + CNT_W'(1);
        unique case (outcome)
          OUT_WIN:   begin win_d  = 1'b1; state_d = S_DONE; end
          OUT_LOSE:  begin lose_d = 1'b1; state_d = S_DONE; end
          OUT_POINT: begin point_d = sum_q; state_d = S_POINT; end
          default:   state_d = S_POINT;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      // Reset high so a start held through reset must drop before it counts.
      start_q    <= 1'b1;
      d2_armed_q <= 1'b0;
      roll_en_q  <= 1'b0;
      die1_q     <= '0;
      die2_q     <= '0;
      sum_q      <= '0;
      point_q    <= '0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      throws_q   <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      d2_armed_q <= (state_q == S_D2);
      roll_en_q  <= (state_d == S_D1) || (state_d == S_D2);
      die1_q     <= die1_d;
      die2_q     <= die2_d;
      sum_q      <= sum_d;
      point_q    <= point_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      throws_q   <= throws_d;
      gap_q      <= gap_d;
    end
  end

  assign roll_en     = roll_en_q;
  assign die1        = die1_q;
  assign die2        = die2_q;
  assign sum         = sum_q;
  assign point       = point_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign throws      = throws_q;
  assign point_valid = (point_q != '0) && !win_q && !lose_q;
  assign busy        = (state_q == S_D1) || (state_q == S_GAP) ||
                       (state_q == S_D2) || (state_q == S_EVAL);

endmodule

// File: tb/tb_craps_ctrl.sv
// Self-checking bench for craps_ctrl with a game-level reference model.
module tb_craps_ctrl;
  localparam int GAP = 2;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, roll_choose;
  logic [2:0]    roll_num;
  logic          roll_en, point_valid, win, lose, busy;
  logic [2:0]    die1, die2;
  logic [3:0]    sum, point;
  logic [CW-1:0] throws;

  int n_tests = 0;
  int n_fail  = 0;

  int m_point, m_throws;
  bit m_win, m_lose;

  craps_ctrl #(.GAP_CYCLES(GAP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .roll_num(roll_num),
    .roll_choose(roll_choose), .roll_en(roll_en), .die1(die1), .die2(die2),
    .sum(sum), .point(point), .point_valid(point_valid), .win(win),
    .lose(lose), .busy(busy), .throws(throws)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    m_point = 0; m_throws = 0; m_win = 0; m_lose = 0;
  endfunction

  function automatic void model_throw(input int a, input int b);
    int s;
    s = a + b;
    if (m_throws < 255) m_throws++;
    if (m_point == 0) begin
      if (s == 7 || s == 11) m_win = 1;
      else if (s == 2 || s == 3 || s == 12) m_lose = 1;
      else m_point = s;
    end else if (s == m_point) m_win = 1;
    else if (s == 7) m_lose = 1;
  endfunction

  task automatic press_start();
    if (m_win || m_lose) model_clear();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic throw_dice(input int a, input int b, input bit pulse);
    int n;
    bit seen;
    logic [26:0] act, exp;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (roll_en) begin seen = 1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen) begin
      $display("FAIL d1_wait: roll_en=%0b required 1 within 20 cycles", roll_en);
      n_fail++;
      return;
    end
    roll_choose = 1'b1;
    roll_num = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'd7;
    @(negedge clk);
    n_tests++;
    if (roll_en !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL invalid_num: roll_en=%0b busy=%0b required 1 1", roll_en, busy);
      n_fail++;
    end
    roll_num = 3'(a);
    @(negedge clk);
    roll_choose = 1'b0; roll_num = 3'd0;
    n = 0;
    while (!roll_en && n < 50) begin
      start = (pulse && n == 0);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    n_tests++;
    if (n != GAP) begin
      $display("FAIL gap_len: low cycles=%0d required %0d", n, GAP);
      n_fail++;
      if (n >= 50) return;
    end
    roll_choose = 1'b1;
    roll_num = 3'((b % 6) + 1);
    @(negedge clk);
    roll_num = 3'(b);
    @(negedge clk);
    roll_choose = 1'b0; roll_num = 3'd0;
    n_tests++;
    if ({busy, roll_en, sum} !== {1'b1, 1'b0, 4'(a + b)}) begin
      $display("FAIL eval: busy=%0b roll_en=%0b sum=%0d required 1 0 %0d",
               busy, roll_en, sum, a + b);
      n_fail++;
    end
    @(negedge clk);
    model_throw(a, b);
    act = {die1, die2, sum, point, point_valid, win, lose, busy, roll_en, throws};
    exp = {3'(a), 3'(b), 4'(a + b), 4'(m_point),
           (m_point != 0) && !m_win && !m_lose, m_win, m_lose, 1'b0, 1'b0, 8'(m_throws)};
    n_tests++;
    if (act !== exp) begin
      $display("FAIL result(%0d,%0d): got=%h required=%h", a, b, act, exp);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; roll_choose = 1'b0; roll_num = 3'd0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({roll_en, die1, die2, sum, point, point_valid, win, lose, busy, throws} !== '0) begin
      $display("FAIL reset: outputs=%h required 0",
               {roll_en, die1, die2, sum, point, point_valid, win, lose, busy, throws});
      n_fail++;
    end
  endtask

  task automatic test_natural();
    press_start(); throw_dice(3, 4, 0);
  endtask

  task automatic test_craps();
    press_start(); throw_dice(1, 1, 0);
    press_start(); throw_dice(6, 6, 0);
  endtask

  task automatic test_point_make();
    press_start(); throw_dice(2, 2, 0);
    press_start(); throw_dice(5, 4, 0);
    press_start(); throw_dice(1, 3, 0);
  endtask

  task automatic test_seven_out();
    press_start(); throw_dice(4, 6, 0);
    press_start(); throw_dice(3, 4, 0);
  endtask

  task automatic test_back_to_back();
    press_start(); throw_dice(5, 3, 1);
    press_start(); throw_dice(2, 4, 1);
    press_start(); throw_dice(6, 2, 1);
  endtask

  task automatic test_reset_gap();
    press_start();
    for (int i = 0; i < 20 && !roll_en; i++) @(negedge clk);
    roll_choose = 1'b1; roll_num = 3'd5;
    @(negedge clk);
    roll_choose = 1'b0; roll_num = 3'd0;
    start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({roll_en, die1, die2, sum, point, point_valid, win, lose, busy, throws} !== '0) begin
      $display("FAIL async_reset: outputs=%h required 0",
               {roll_en, die1, die2, sum, point, point_valid, win, lose, busy, throws});
      n_fail++;
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({busy, roll_en} !== 2'b00) begin
      $display("FAIL held_start: busy=%0b roll_en=%0b required 0 0", busy, roll_en);
      n_fail++;
    end
    start = 1'b0;
    model_clear();
    press_start(); throw_dice(2, 5, 0);
  endtask

  task automatic test_random();
    int a, b, k;
    for (int g = 0; g < 6; g++) begin
      press_start();
      k = 0;
      do begin
        a = $urandom_range(1, 6);
        b = $urandom_range(1, 6);
        throw_dice(a, b, ($urandom_range(0, 3) == 0));
        k++;
        if (!m_win && !m_lose && k < 40) press_start();
      end while (!m_win && !m_lose && k < 40);
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_craps();
    test_point_make();
    test_seven_out();
    test_back_to_back();
    test_reset_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
